seq_normalizer_16bit: RTL and testbench



---
 rtl/seq_normalizer_16bit_pkg.sv | 22 ++
 rtl/seq_normalizer_16bit_norm_step.sv | 31 +++
 rtl/seq_normalizer_16bit.sv | 142 ++++++++++++++
 tb/tb_seq_normalizer_16bit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_normalizer_16bit_pkg.sv
// -----------------------------------------------------------------------------
// seq_normalizer_16bit_pkg
// Shared definitions for the iterative 16-bit normalizer:
//   - DATA_W / CNT_W : operand width (16) and shift-count width (4)
//   - DIR_LEFT / DIR_RIGHT : direction encodings (toward bit 15 / toward bit 0)
//   - state_t : controller states IDLE, SHIFT, DONE
// -----------------------------------------------------------------------------
package seq_normalizer_16bit_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_normalizer_16bit_norm_step.sv
// -----------------------------------------------------------------------------
// norm_step_16bit
// One cycle of normalization work, purely combinational.
// Ports:
//   data      in  16  current working word
//   dir       in  1   DIR_LEFT: target bit 15, DIR_RIGHT: target bit 0
//   next_data out 16  data shifted one place toward the target, zero-filled
//   hit       out 1   target bit of data is already set
//   is_zero   out 1   data is all zeros
// -----------------------------------------------------------------------------
module norm_step_16bit
  import seq_normalizer_16bit_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic              dir,
  output logic [DATA_W-1:0] next_data,
  output logic              hit,
  output logic              is_zero
);

  always_comb begin
    is_zero   = (data == '0);
    hit       = data[DATA_W-1];
    next_data = {data[DATA_W-2:0], 1'b0};
    if (dir == DIR_RIGHT) begin
      hit       = data[0];
      next_data = {1'b0, data[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/seq_normalizer_16bit.sv
// -----------------------------------------------------------------------------
// seq_normalizer_16bit
// Iterative normalizer: shifts the operand one place per cycle until its
// leading one sits at bit 15 (or, in right mode, its trailing one at bit 0),
// and reports the normalized word and the number of places shifted.
//
// Optional feature macro: NORM_BIDIR_EN
//   defined   -> 'choice' port exists; choice=1 normalizes toward bit 0.
//   undefined -> no 'choice' port; left (MSB) normalization only.
//
// Ports:
//   clk    in  1   clock, rising edge
//   reset  in  1   synchronous, active-high
//   start  in  1   request, honoured only while ready=1
//   a      in  16  operand, captured on the accepted start
//   choice in  1   direction, 0=left 1=right (NORM_BIDIR_EN only)
//   ready  out 1   idle, able to accept start
//   done   out 1   one-cycle pulse; y/amt/zero valid from this cycle on
//   y      out 16  normalized word
//   amt    out 4   positions shifted (0..15)
//   zero   out 1   operand was zero (y=0, amt=0)
//
// Latency from the accepting edge: SHIFT lasts amt+1 cycles, done arrives in
// cycle amt+2. Results hold until the next DONE, except zero, which clears on
// every accepted start.
// -----------------------------------------------------------------------------
module seq_normalizer_16bit
  import seq_normalizer_16bit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
`ifdef NORM_BIDIR_EN
  input  logic              choice,
`endif
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] y,
  output logic [CNT_W-1:0]  amt,
  output logic              zero
);

  // A nonzero operand terminates by the 15th shift, so saturation never
  // engages in practice; it only keeps the counter bounded by construction.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t state, state_nxt;

  logic [DATA_W-1:0] data_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              dir_sel;
  logic [DATA_W-1:0] step_data;
  logic              step_hit;
  logic              step_zero;
  logic              finish;

`ifdef NORM_BIDIR_EN
  logic dir_p0;
  assign dir_sel = dir_p0;
`else
  assign dir_sel = DIR_LEFT;
`endif

  norm_step_16bit u_step (
    .data      (data_p0),
    .dir       (dir_sel),
    .next_data (step_data),
    .hit       (step_hit),
    .is_zero   (step_zero)
  );

  // SHIFT ends when the word is empty or the target bit is already in place.
  assign finish = step_zero | step_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage 0: working register and shift counter; output registers load
  // on the edge that enters DONE so results are valid alongside done ----
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p0 <= '0;
      cnt_p0  <= '0;
`ifdef NORM_BIDIR_EN
      dir_p0  <= DIR_LEFT;
`endif
      y       <= '0;
      amt     <= '0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_p0 <= a;
            cnt_p0  <= '0;
`ifdef NORM_BIDIR_EN
            dir_p0  <= choice;
`endif
            zero    <= 1'b0;
          end
        end
        SHIFT: begin
          if (finish) begin
            y    <= data_p0;
            amt  <= cnt_p0;
            zero <= step_zero;
          end else begin
            data_p0 <= step_data;
            cnt_p0  <= sat_inc(cnt_p0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_normalizer_16bit.sv
module tb_seq_normalizer_16bit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
`ifdef NORM_BIDIR_EN
  logic        choice = 1'b0;
`endif
  logic        ready;
  logic        done;
  logic [15:0] y;
  logic [3:0]  amt;
  logic        zero;

  int checks = 0;
  int errors = 0;

  seq_normalizer_16bit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
`ifdef NORM_BIDIR_EN
    .choice (choice),
`endif
    .ready  (ready),
    .done   (done),
    .y      (y),
    .amt    (amt),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request on the negative edge; return in cycle 1 (just after
  // the accepting edge) with start released.
  task automatic launch(input logic [15:0] av, input logic dir);
    @(negedge clk);
    a     = av;
    start = 1'b1;
`ifdef NORM_BIDIR_EN
    choice = dir;
`else
    if (dir) $display("note: right mode requested in a left-only build");
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Walk cycles from cycle 1 until done (bounded). Optionally re-assert
  // start with a different operand during cycles 3..4 to show it is ignored.
  task automatic wait_done(input bit inject, output int cyc, output int ready_hi);
    cyc = 1;
    ready_hi = 0;
    if (ready === 1'b1) ready_hi++;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inject && cyc == 3) begin start = 1'b1; a = 16'hFFFF; end
      if (inject && cyc == 5) start = 1'b0;
      if (ready === 1'b1 && done !== 1'b1) ready_hi++;
    end
  endtask

  function automatic int lead_zeros(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return 15 - i;
    return 0;
  endfunction

  function automatic int trail_zeros(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  int cyc, rhi;
  logic [15:0] rv;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_y", y, 16'h0000);
    chk("rst_amt", amt, 0);
    chk("rst_zero", zero, 0);

    // 0x8000: already normalized
    launch(16'h8000, 1'b0);
    chk("c1_ready_low", ready, 0);
    wait_done(1'b0, cyc, rhi);
    chk("8000_cycle", cyc, 2);
    chk("8000_y", y, 16'h8000);
    chk("8000_amt", amt, 0);
    chk("8000_zero", zero, 0);
    @(posedge clk); #1;
    chk("8000_ready_back", ready, 1);
    chk("8000_done_pulse", done, 0);

    // 0x0001: longest case
    launch(16'h0001, 1'b0);
    wait_done(1'b0, cyc, rhi);
    chk("0001_cycle", cyc, 17);
    chk("0001_y", y, 16'h8000);
    chk("0001_amt", amt, 15);
    chk("0001_ready_busy", rhi, 0);
    @(posedge clk); #1;
    chk("0001_ready_back", ready, 1);

    // zero operand
    launch(16'h0000, 1'b0);
    wait_done(1'b0, cyc, rhi);
    chk("0000_cycle", cyc, 2);
    chk("0000_y", y, 16'h0000);
    chk("0000_amt", amt, 0);
    chk("0000_zero", zero, 1);
    @(posedge clk); #1;
    chk("0000_zero_hold", zero, 1);

    // 0x00F0 with a start re-asserted while busy
    launch(16'h00F0, 1'b0);
    chk("f0_zero_cleared", zero, 0);
    chk("f0_y_held", y, 16'h0000);
    wait_done(1'b1, cyc, rhi);
    chk("00f0_cycle", cyc, 10);
    chk("00f0_y", y, 16'hF000);
    chk("00f0_amt", amt, 8);
    @(posedge clk); #1;
    chk("00f0_ready_back", ready, 1);

    // next request after ready rises
    launch(16'h1234, 1'b0);
    wait_done(1'b0, cyc, rhi);
    chk("1234_cycle", cyc, 5);
    chk("1234_y", y, 16'h91A0);
    chk("1234_amt", amt, 3);
    @(posedge clk); #1;

    // reset in cycle 5 of 0x0003
    launch(16'h0003, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_y", y, 16'h0000);
    chk("mid_rst_amt", amt, 0);
    chk("mid_rst_zero", zero, 0);
    cyc = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (done === 1'b1) cyc++;
    end
    chk("mid_rst_no_done", cyc, 0);

    // start in the same cycle as reset is dropped
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    a     = 16'h8000;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_drop", ready, 1);

    // left-mode sweep against an independent leading-zero model
    for (int i = 0; i < 6; i++) begin
      rv = 16'($urandom_range(1, 16'hFFFF));
      launch(rv, 1'b0);
      wait_done(1'b0, cyc, rhi);
      chk("sw_l_amt", amt, lead_zeros(rv));
      chk("sw_l_y", y, rv << amt);
      chk("sw_l_msb", y[15], 1);
      chk("sw_l_cycle", cyc, lead_zeros(rv) + 2);
      @(posedge clk); #1;
    end

`ifdef NORM_BIDIR_EN
    // right mode: trailing-zero normalization
    launch(16'h0A00, 1'b1);
    wait_done(1'b0, cyc, rhi);
    chk("r0a00_cycle", cyc, 11);
    chk("r0a00_y", y, 16'h0005);
    chk("r0a00_amt", amt, 9);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      rv = 16'($urandom_range(1, 16'hFFFF));
      launch(rv, 1'b1);
      wait_done(1'b0, cyc, rhi);
      chk("sw_r_amt", amt, trail_zeros(rv));
      chk("sw_r_y", y, rv >> amt);
      chk("sw_r_lsb", y[0], 1);
      @(posedge clk); #1;
    end
`else
    rv = 16'h0001;
    chk("tz_model_unused", trail_zeros(rv), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
